// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// default operand width.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fa.sv
// 1-bit full adder cell; the per-bit datapath of the serial adder.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain sum/majority equations, purely combinational.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are captured on start, then streamed
// LSB-first through a single full adder with the carry held in a flop.
// The result and carry-out are registered on the last bit and held until the
// next add completes.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// SHIFT | one operand bit pair added per cycle, WIDTH cycles
// DONE  | one-cycle done pulse, then back to IDLE
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds only the upper WIDTH-1 result bits; the bit that would fall off the
  // bottom on the final shift is never needed.
  logic [WIDTH-2:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             c_bit;

  fa u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (s_bit),
    .cout (c_bit)
  );

  // Sequencer, shift datapath and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= cin_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          res_sr <= (WIDTH-1)'({s_bit, res_sr} >> 1);
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= c_bit;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_out  <= {s_bit, res_sr};
            cout_out <= c_bit;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: a WIDTH=8 and a WIDTH=4 instance share one clock and
// are checked every cycle against a timing/arithmetic model of the adder.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_d   [2];
  logic       start_d [2];
  logic [7:0] a_d     [2];
  logic [7:0] b_d     [2];
  logic       cin_d   [2];

  logic       busy8, done8, cout8, busy4, done4, cout4;
  logic [7:0] sum8;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // model state per channel: k = cycles since accept, -1 when idle
  int k     [2];
  int e_sum [2];
  int e_cout[2];
  int pend  [2];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst_d[0]), .start(start_d[0]),
    .a_in(a_d[0]), .b_in(b_d[0]), .cin_in(cin_d[0]),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst_d[1]), .start(start_d[1]),
    .a_in(a_d[1][3:0]), .b_in(b_d[1][3:0]), .cin_in(cin_d[1]),
    .busy(busy4), .done(done4), .sum_out(sum4), .cout_out(cout4)
  );

  function automatic int wid(input int ch);
    return (ch == 0) ? 8 : 4;
  endfunction

  function automatic logic get_busy(input int ch);
    return (ch == 0) ? busy8 : busy4;
  endfunction

  function automatic logic get_done(input int ch);
    return (ch == 0) ? done8 : done4;
  endfunction

  function automatic int get_sum(input int ch);
    return (ch == 0) ? int'(sum8) : int'(sum4);
  endfunction

  function automatic int get_cout(input int ch);
    return (ch == 0) ? int'(cout8) : int'(cout4);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               nm, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: an add accepted in idle finishes W cycles later with
  // {cout,sum} = a+b+cin, done lasts one cycle, idle again one cycle after.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int w, m;
      w = wid(i);
      m = (1 << w) - 1;
      if (rst_d[i]) begin
        k[i] = -1; e_sum[i] = 0; e_cout[i] = 0;
      end else if (k[i] < 0) begin
        if (start_d[i]) begin
          k[i] = 0;
          pend[i] = (int'(a_d[i]) & m) + (int'(b_d[i]) & m) + int'(cin_d[i]);
        end
      end else begin
        k[i] = k[i] + 1;
        if (k[i] == w) begin
          e_sum[i]  = pend[i] & m;
          e_cout[i] = (pend[i] >> w) & 1;
        end else if (k[i] == w + 1) begin
          k[i] = -1;
        end
      end
    end
  end

  // Cycle-by-cycle compare of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int w;
        w = wid(i);
        chk($sformatf("busy%0d", i), int'(get_busy(i)),
            int'(k[i] >= 0 && k[i] < w));
        chk($sformatf("done%0d", i), int'(get_done(i)), int'(k[i] == w));
        chk($sformatf("sum%0d", i), get_sum(i), e_sum[i]);
        chk($sformatf("cout%0d", i), get_cout(i), e_cout[i]);
      end
    end
  end

  // One add on channel ch; inputs are scrambled after accept. lat = number of
  // negedge samples after the accept edge until done is seen.
  task automatic do_add(input int ch, input logic [7:0] a, input logic [7:0] b,
                        input logic c, output int lat);
    bit got;
    start_d[ch] = 1'b1; a_d[ch] = a; b_d[ch] = b; cin_d[ch] = c;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      start_d[ch] = 1'b0;
      a_d[ch] = 8'($urandom); b_d[ch] = 8'($urandom); cin_d[ch] = 1'($urandom);
      if (get_done(ch)) got = 1'b1;
    end
    chk("done_timeout", int'(got), 1);
    @(negedge clk);
  endtask

  initial begin
    int lat, ndone, prev, run;
    bit seen_busy;
    for (int i = 0; i < 2; i++) begin
      rst_d[i] = 1'b1; start_d[i] = 1'b0; a_d[i] = '0; b_d[i] = '0;
      cin_d[i] = 1'b0; k[i] = -1; e_sum[i] = 0; e_cout[i] = 0; pend[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", int'(busy8), 0);
    chk("rst_done", int'(done8), 0);
    chk("rst_sum", int'(sum8), 0);
    chk("rst_cout", int'(cout8), 0);
    rst_d[0] = 1'b0; rst_d[1] = 1'b0;
    @(negedge clk);

    // 1: FF + 01 + 0
    do_add(0, 8'hFF, 8'h01, 1'b0, lat);
    chk("t1_latency", lat, 9);
    chk("t1_sum", int'(sum8), 8'h00);
    chk("t1_cout", int'(cout8), 1);
    chk("t1_model_sum", e_sum[0], 0);
    chk("t1_model_cout", e_cout[0], 1);

    // 2: 5A + A5 + 1, then 100 + 27
    do_add(0, 8'h5A, 8'hA5, 1'b1, lat);
    chk("t2a_sum", int'(sum8), 8'h00);
    chk("t2a_cout", int'(cout8), 1);
    do_add(0, 8'd100, 8'd27, 1'b0, lat);
    chk("t2b_sum", int'(sum8), 127);
    chk("t2b_cout", int'(cout8), 0);
    chk("t2b_model_sum", e_sum[0], 127);

    // all ones with carry in
    do_add(0, 8'hFF, 8'hFF, 1'b1, lat);
    chk("ones_sum", int'(sum8), 8'hFF);
    chk("ones_cout", int'(cout8), 1);

    // 3: start re-pulsed 3 cycles into an add
    start_d[0] = 1'b1; a_d[0] = 8'd20; b_d[0] = 8'd22; cin_d[0] = 1'b0;
    ndone = 0;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      start_d[0] = (n == 3);
      a_d[0] = 8'd200; b_d[0] = 8'd99; cin_d[0] = 1'b1;
      if (done8) ndone++;
      if (n == 4) start_d[0] = 1'b0;
    end
    chk("t3_done_count", ndone, 1);
    chk("t3_sum", int'(sum8), 42);
    chk("t3_cout", int'(cout8), 0);

    // 4: reset in the 4th SHIFT cycle (previous result is nonzero)
    do_add(0, 8'd100, 8'd27, 1'b0, lat);
    start_d[0] = 1'b1; a_d[0] = 8'h0F; b_d[0] = 8'h0F; cin_d[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start_d[0] = 1'b0;
    end
    rst_d[0] = 1'b1;
    @(negedge clk);
    rst_d[0] = 1'b0;
    chk("t4_busy", int'(busy8), 0);
    chk("t4_sum", int'(sum8), 0);
    chk("t4_cout", int'(cout8), 0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    chk("t4_no_done", ndone, 0);
    do_add(0, 8'd77, 8'd23, 1'b1, lat);
    chk("t4_next_sum", int'(sum8), 101);

    // reset coincident with start
    rst_d[0] = 1'b1; start_d[0] = 1'b1;
    @(negedge clk);
    rst_d[0] = 1'b0; start_d[0] = 1'b0;
    chk("rst_start_busy", int'(busy8), 0);
    @(negedge clk);
    chk("rst_start_idle", int'(busy8), 0);

    // 5: start held high for 30 cycles with fresh random operands
    start_d[0] = 1'b1; a_d[0] = 8'($urandom); b_d[0] = 8'($urandom);
    ndone = 0; prev = -1; run = 0; seen_busy = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      a_d[0] = 8'($urandom); b_d[0] = 8'($urandom); cin_d[0] = 1'($urandom);
      if (done8) begin
        ndone++;
        if (prev >= 0) chk("t5_done_period", n - prev, 10);
        prev = n;
      end
      if (busy8) begin
        if (seen_busy && run > 0) chk("t5_busy_gap", run, 2);
        seen_busy = 1'b1; run = 0;
      end else begin
        run++;
      end
    end
    start_d[0] = 1'b0;
    chk("t5_done_count", ndone, 3);
    repeat (12) @(negedge clk);

    // random adds on the 8-bit instance
    repeat (20) begin
      logic [7:0] ra, rb;
      logic rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      do_add(0, ra, rb, rc, lat);
      chk("rnd_result", int'({cout8, sum8}), int'(ra) + int'(rb) + int'(rc));
    end

    // 6: WIDTH=4 exhaustive
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          do_add(1, 8'(a), 8'(b), 1'(c), lat);
          chk("w4_result", int'({cout4, sum4}), a + b + c);
        end
    chk("w4_latency", lat, 5);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
